// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: logical/arithmetic shifts and rotates, one level per shift-amount bit.
// A single global stall (advance) moves every stage together; the tag rides alongside the data.
module shifter_pipe #(
  parameter int WIDTH     = 32,
  parameter int SW        = $clog2(WIDTH) + 1,
  parameter int FULL_PIPE = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SW-1:0]    in_b,
  input  logic             in_dirt,
  input  logic             in_sign,
  input  logic             in_rotate,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LVL   = $clog2(WIDTH);
  localparam int AMT_T = (LVL * (LVL + 1)) / 2;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             dirt;
    logic             rot;
    logic             fill;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // st[i] feeds level i. Each level only carries the amount bits still to be consumed,
  // so the amounts live in a triangular vector: level i owns LVL-i bits at offset OFF(i).
  stage_t [LVL-1:0] st;
  logic [AMT_T-1:0] amt_flat;
  stage_t           in_stage;
  logic             advance;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_result_d, out_result_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    in_stage       = '0;
    in_stage.valid = in_valid;
    in_stage.value = in_a;
    in_stage.dirt  = in_dirt;
    in_stage.rot   = in_rotate;
    in_stage.fill  = in_dirt & in_sign & in_a[WIDTH-1] & ~in_rotate;
    in_stage.sat   = in_b[SW-1] & ~in_rotate;
    in_stage.tag   = in_tag;
  end

  assign st[0]             = in_stage;
  assign amt_flat[LVL-1:0] = in_b[LVL-1:0];

  for (genvar i = 0; i < LVL; i++) begin : g_lvl
    localparam int K   = LVL - 1 - i;
    localparam int S   = 1 << K;
    localparam int OFF = i * LVL - (i * (i - 1)) / 2;

    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] shifted;

    assign v = st[i].value;

    always_comb begin
      shifted = v;
      if (amt_flat[OFF + K]) begin
        if (st[i].rot) begin
          shifted = st[i].dirt ? ((v >> S) | (v << (WIDTH - S)))
                               : ((v << S) | (v >> (WIDTH - S)));
        end else if (st[i].dirt) begin
          shifted = (v >> S) | ({WIDTH{st[i].fill}} & ~({WIDTH{1'b1}} >> S));
        end else begin
          shifted = v << S;
        end
      end
    end

    if (i < LVL - 1) begin : g_mid
      localparam int OFF_N = OFF + K + 1;
      stage_t       stg_d;
      logic [K-1:0] amt_d;

      always_comb begin
        stg_d       = st[i];
        stg_d.value = shifted;
      end
      assign amt_d = amt_flat[OFF +: K];

      if (FULL_PIPE != 0) begin : g_reg
        stage_t       stg_q;
        logic [K-1:0] amt_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            stg_q <= '0;
            amt_q <= '0;
          end else if (advance) begin
            stg_q <= stg_d;
            amt_q <= amt_d;
          end
        end
        assign st[i+1]              = stg_q;
        assign amt_flat[OFF_N +: K] = amt_q;
      end else begin : g_comb
        assign st[i+1]              = stg_d;
        assign amt_flat[OFF_N +: K] = amt_d;
      end
    end else begin : g_last
      // Saturation overrides the shifted value; idle outputs are forced to zero.
      always_comb begin
        out_valid_d  = st[i].valid;
        out_result_d = '0;
        out_tag_d    = '0;
        if (st[i].valid) begin
          out_result_d = st[i].sat ? {WIDTH{st[i].fill}} : shifted;
          out_tag_d    = st[i].tag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (advance) begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule
